// File: rtl/norm_shift_controller.sv
// Normalization sequencer for the fraction datapath.
// It finds the leading one with a serial scan, one bit per cycle. It drives an
// external left-shifter, then returns the normalized fraction and the adjusted
// exponent through valid/ready handshakes.
module norm_shift_controller #(
  parameter int FRAC_W = 18,
  parameter int EXP_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [FRAC_W-1:0] in_fraction_i,
  input  logic [EXP_W-1:0]  in_exponent_i,
  output logic [FRAC_W-1:0] sh_fraction_o,
  output logic [EXP_W-1:0]  sh_amount_o,
  input  logic [FRAC_W-1:0] sh_result_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [FRAC_W-1:0] out_fraction_o,
  output logic [EXP_W-1:0]  out_exponent_o,
  output logic              out_zero_o,
  output logic              out_underflow_o,
  output logic              busy_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    APPLY = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [FRAC_W-1:0] frac_q, frac_d;
  logic [EXP_W-1:0]  exp_q, exp_d;
  logic [EXP_W-1:0]  count_q, count_d;
  logic [FRAC_W-1:0] outFrac_q, outFrac_d;
  logic [EXP_W-1:0]  outExp_q, outExp_d;
  logic              outZero_q, outZero_d;
  logic              outUnderflow_q, outUnderflow_d;
  logic              scanBit;

  // Select the fraction bit under test, counting down from the MSB by the scan count
  always_comb begin
    scanBit = 1'b0;
    for (int i = 0; i < FRAC_W; i++) begin
      if (count_q == EXP_W'(i)) begin
        scanBit = frac_q[FRAC_W-1-i];
      end
    end
  end

  // Next-state and next-register logic for the IDLE/SCAN/APPLY/DONE sequence
  always_comb begin
    state_d        = state_q;
    frac_d         = frac_q;
    exp_d          = exp_q;
    count_d        = count_q;
    outFrac_d      = outFrac_q;
    outExp_d       = outExp_q;
    outZero_d      = outZero_q;
    outUnderflow_d = outUnderflow_q;
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          frac_d         = in_fraction_i;
          exp_d          = in_exponent_i;
          count_d        = '0;
          outUnderflow_d = 1'b0;
          if (in_fraction_i == '0) begin
            outFrac_d = '0;
            outExp_d  = '0;
            outZero_d = 1'b1;
            state_d   = DONE;
          end else begin
            outZero_d = 1'b0;
            state_d   = SCAN;
          end
        end
      end
      SCAN: begin
        if (scanBit) begin
          outUnderflow_d = 1'b0;
          state_d        = APPLY;
        end else if (count_q == exp_q) begin
          outUnderflow_d = 1'b1;
          state_d        = APPLY;
        end else begin
          count_d = count_q + EXP_W'(1);
        end
      end
      APPLY: begin
        outFrac_d = sh_result_i;
        outExp_d  = exp_q - count_q;
        state_d   = DONE;
      end
      DONE: begin
        if (out_ready_i) begin
          outFrac_d      = '0;
          outExp_d       = '0;
          outZero_d      = 1'b0;
          outUnderflow_d = 1'b0;
          count_d        = '0;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any operand in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      frac_q         <= '0;
      exp_q          <= '0;
      count_q        <= '0;
      outFrac_q      <= '0;
      outExp_q       <= '0;
      outZero_q      <= 1'b0;
      outUnderflow_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      frac_q         <= frac_d;
      exp_q          <= exp_d;
      count_q        <= count_d;
      outFrac_q      <= outFrac_d;
      outExp_q       <= outExp_d;
      outZero_q      <= outZero_d;
      outUnderflow_q <= outUnderflow_d;
    end
  end

  assign in_ready_o      = (state_q == IDLE);
  assign busy_o          = (state_q != IDLE);
  assign out_valid_o     = (state_q == DONE);
  assign sh_fraction_o   = frac_q;
  assign sh_amount_o     = count_q;
  assign out_fraction_o  = outFrac_q;
  assign out_exponent_o  = outExp_q;
  assign out_zero_o      = outZero_q;
  assign out_underflow_o = outUnderflow_q;

endmodule

// File: tb/tb_norm_shift_controller.sv
// Self-checking bench for norm_shift_controller.
// The reference model computes the leading-zero count with plain arithmetic and
// caps it by the exponent. It then predicts the result, the flags and the latency.
module tb_norm_shift_controller;

  logic        clk;
  logic        rst;
  logic        inValid;
  logic        inReady;
  logic [17:0] inFraction;
  logic [7:0]  inExponent;
  logic [17:0] shFraction;
  logic [7:0]  shAmount;
  logic [17:0] shResult;
  logic        outValid;
  logic        outReady;
  logic [17:0] outFraction;
  logic [7:0]  outExponent;
  logic        outZero;
  logic        outUnderflow;
  logic        busy;

  int checks = 0;
  int errors = 0;

  norm_shift_controller #(.FRAC_W(18), .EXP_W(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid_i     (inValid),
    .in_ready_o     (inReady),
    .in_fraction_i  (inFraction),
    .in_exponent_i  (inExponent),
    .sh_fraction_o  (shFraction),
    .sh_amount_o    (shAmount),
    .sh_result_i    (shResult),
    .out_valid_o    (outValid),
    .out_ready_i    (outReady),
    .out_fraction_o (outFraction),
    .out_exponent_o (outExponent),
    .out_zero_o     (outZero),
    .out_underflow_o(outUnderflow),
    .busy_o         (busy)
  );

  // The external combinational left-shifter
  assign shResult = shFraction << shAmount;

  // Free-running clock, 10 time units per period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Reference model: leading zeros capped by the exponent
  task automatic model(input logic [17:0] f, input logic [7:0] e,
                       output logic [17:0] mFrac, output logic [7:0] mExp,
                       output logic mZero, output logic mUf,
                       output int mShift, output int mLat);
    int lz = 0;
    while (lz < 18 && f[17-lz] == 1'b0) lz++;
    if (f == 18'd0) begin
      mFrac = 18'd0; mExp = 8'd0; mZero = 1'b1; mUf = 1'b0; mShift = 0; mLat = 0;
    end else begin
      mShift = (lz > int'(e)) ? int'(e) : lz;
      mUf    = (lz > int'(e));
      mFrac  = f << mShift;
      mExp   = e - 8'(mShift);
      mZero  = 1'b0;
      mLat   = mShift + 2;
    end
  endtask

  // Present one operand and leave the time just after the acceptance edge
  task automatic applyStimulus(input logic [17:0] f, input logic [7:0] e);
    int waitCycles = 0;
    @(negedge clk);
    while (!inReady && waitCycles < 50) begin
      @(negedge clk);
      waitCycles++;
    end
    check("in_ready_before_accept", 32'(inReady), 32'd1);
    inValid    = 1'b1;
    inFraction = f;
    inExponent = e;
    @(posedge clk);
    #1;
    inValid    = 1'b0;
    inFraction = 18'($urandom);
    inExponent = 8'($urandom);
  endtask

  // Wait for the result, then check latency, fields and hold-while-stalled.
  // Finally complete the handshake and check the return to IDLE.
  task automatic checkOutput(input logic [17:0] f, input logic [7:0] e, input int stall);
    logic [17:0] mFrac;
    logic [7:0]  mExp;
    logic        mZero, mUf;
    int          mShift, mLat;
    int          n = 0;
    model(f, e, mFrac, mExp, mZero, mUf, mShift, mLat);
    while (!outValid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (stall > 0) outReady = 1'b0;
    check("latency", 32'(n), 32'(mLat));
    for (int k = 0; k <= stall; k++) begin
      check("out_valid", 32'(outValid), 32'd1);
      check("out_fraction", 32'(outFraction), 32'(mFrac));
      check("out_exponent", 32'(outExponent), 32'(mExp));
      check("out_zero", 32'(outZero), 32'(mZero));
      check("out_underflow", 32'(outUnderflow), 32'(mUf));
      check("sh_amount", 32'(shAmount), 32'(mShift));
      check("sh_fraction", 32'(shFraction), 32'(f));
      check("in_ready_busy", 32'(inReady), 32'd0);
      if (k < stall) begin
        @(negedge clk);
        inValid    = 1'b1;
        inFraction = 18'($urandom);
        inExponent = 8'($urandom);
        @(posedge clk);
        #1;
      end
    end
    @(negedge clk);
    inValid  = 1'b0;
    outReady = 1'b1;
    @(posedge clk);
    #1;
    check("valid_after_handshake", 32'(outValid), 32'd0);
    check("ready_after_handshake", 32'(inReady), 32'd1);
    check("flags_after_handshake", {30'd0, outZero, outUnderflow}, 32'd0);
    check("busy_after_handshake", 32'(busy), 32'd0);
  endtask

  initial begin
    int quiet;
    rst        = 1'b1;
    inValid    = 1'b0;
    inFraction = 18'd0;
    inExponent = 8'd0;
    outReady   = 1'b1;
    #1;
    check("reset_out_valid", 32'(outValid), 32'd0);
    check("reset_in_ready", 32'(inReady), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_outputs", {outZero, outUnderflow, outExponent, outFraction}, 32'd0);
    check("reset_shifter", {6'd0, shAmount, shFraction}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] directed cases");
    applyStimulus(18'h00400, 8'd20); checkOutput(18'h00400, 8'd20, 0);
    applyStimulus(18'h00010, 8'd5);  checkOutput(18'h00010, 8'd5, 0);
    applyStimulus(18'h00000, 8'd77); checkOutput(18'h00000, 8'd77, 0);
    applyStimulus(18'h3FFFF, 8'd1);  checkOutput(18'h3FFFF, 8'd1, 0);
    applyStimulus(18'h3FFFF, 8'd0);  checkOutput(18'h3FFFF, 8'd0, 0);
    applyStimulus(18'h00001, 8'd0);  checkOutput(18'h00001, 8'd0, 0);
    applyStimulus(18'h00001, 8'd17); checkOutput(18'h00001, 8'd17, 0);
    applyStimulus(18'h00001, 8'd200); checkOutput(18'h00001, 8'd200, 0);

    $display("[TB] stall in DONE with new data pulsed");
    applyStimulus(18'h01234, 8'd9);  checkOutput(18'h01234, 8'd9, 5);
    applyStimulus(18'h00080, 8'd30); checkOutput(18'h00080, 8'd30, 0);

    $display("[TB] reset during SCAN");
    applyStimulus(18'h00001, 8'd30);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midreset_out_valid", 32'(outValid), 32'd0);
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_sh_amount", 32'(shAmount), 32'd0);
    check("midreset_sh_fraction", 32'(shFraction), 32'd0);
    check("midreset_in_ready", 32'(inReady), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    quiet = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      #1;
      if (outValid) quiet++;
    end
    check("no_emit_after_reset", 32'(quiet), 32'd0);
    applyStimulus(18'h00400, 8'd20); checkOutput(18'h00400, 8'd20, 0);

    $display("[TB] randomized cases");
    for (int t = 0; t < 40; t++) begin
      logic [17:0] f;
      logic [7:0]  e;
      f = 18'($urandom) >> $urandom_range(0, 18);
      if ($urandom_range(0, 3) == 0) e = 8'($urandom);
      else e = 8'($urandom_range(0, 20));
      applyStimulus(f, e);
      checkOutput(f, e, int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
